// File: rtl/bpu_pkg.sv
// bpu_pkg: shared counter type, encodings and saturating-update helper for the branch predictor.
package bpu_pkg;
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    return taken ? ((c == CTR_ST) ? c : c + 2'd1) : ((c == CTR_SNT) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/bpu_sat_ctr.sv
// bpu_sat_ctr: combinational 2-bit saturating counter next state.
module bpu_sat_ctr
  import bpu_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t ctr_o
);
  assign ctr_o = ctr_next(ctr_i, taken_i);
endmodule

// File: rtl/bpu_btb_2bit.sv
// bpu_btb_2bit: tagged BTB with 2-bit direction counters and one-cycle registered prediction.
// Define BPU_GSHARE_EN to index the counters by idx^history (gshare) with pred_hist/update_hist ports.
module bpu_btb_2bit
  import bpu_pkg::*;
#(
  parameter  int ENTRIES = 16,
  parameter  int PC_W    = 32,
  parameter  int TAG_W   = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             lookup_valid,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
`ifdef BPU_GSHARE_EN
  output logic [IDX_W-1:0] pred_hist,
  input  logic [IDX_W-1:0] update_hist,
`endif
  input  logic             update_valid,
  input  logic [PC_W-1:0]  update_pc,
  input  logic             update_taken,
  input  logic [PC_W-1:0]  update_target
);
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  ctr_t               ctr_q [ENTRIES];
  logic [IDX_W-1:0]   l_idx, u_idx, l_cidx, u_cidx;
  logic [TAG_W-1:0]   l_tag, u_tag;
  logic               l_hit, u_hit;
  ctr_t               u_ctr_nxt;
  logic               pred_valid_q, pred_taken_q, pred_taken_d;
  logic [PC_W-1:0]    pred_target_q, pred_target_d;
  logic               unused_pc;
  assign unused_pc = ^update_pc;
  assign l_idx = lookup_pc[IDX_W+1:2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[IDX_W+2+TAG_W-1:IDX_W+2];
  assign u_tag = update_pc[IDX_W+2+TAG_W-1:IDX_W+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
`ifdef BPU_GSHARE_EN
  logic [IDX_W-1:0] hist_q, pred_hist_q;
  assign l_cidx = l_idx ^ hist_q;
  assign u_cidx = u_idx ^ update_hist;
  assign pred_hist = pred_hist_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist_q      <= '0;
      pred_hist_q <= '0;
    end else begin
      hist_q <= flush ? '0 : update_valid ? {hist_q[IDX_W-2:0], update_taken} : hist_q;
      if (lookup_valid) pred_hist_q <= hist_q;
    end
`else
  assign l_cidx = l_idx;
  assign u_cidx = u_idx;
`endif
  bpu_sat_ctr u_sat (
    .ctr_i   (ctr_q[u_cidx]),
    .taken_i (update_taken),
    .ctr_o   (u_ctr_nxt)
  );
  always_comb begin
    pred_taken_d  = l_hit && ctr_q[l_cidx][1];
    pred_target_d = pred_taken_d ? tgt_q[l_idx] : lookup_pc + PC_W'(4);
  end
  // Lookups read pre-update state: the prediction is registered from current arrays.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q <= lookup_valid;
      if (lookup_valid) begin
        pred_taken_q  <= pred_taken_d;
        pred_target_q <= pred_target_d;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (flush) begin
      valid_q <= '0;
`ifdef BPU_GSHARE_EN
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
`endif
    end else if (update_valid && (u_hit || update_taken)) begin
      valid_q[u_idx] <= 1'b1;
      ctr_q[u_cidx]  <= u_hit ? u_ctr_nxt : CTR_WT;
    end
  // Tags and targets need no reset; valid gates their use.
  always_ff @(posedge clk)
    if (!rst && !flush && update_valid && update_taken) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= update_target;
    end
  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
endmodule

// File: tb/tb_bpu_btb_2bit.sv
// tb_bpu_btb_2bit: directed plan plus random traffic against an array-based reference model.
module tb_bpu_btb_2bit;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        lookup_valid = 1'b0, update_valid = 1'b0, update_taken = 1'b0;
  logic [31:0] lookup_pc = '0, update_pc = '0, update_target = '0;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  int          n_vec = 0, n_err = 0;
  bit          m_valid [16];
  int          m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  logic        e_valid = 1'b0, e_taken = 1'b0;
  logic [31:0] e_target = '0;

  always #5 clk = ~clk;

  bpu_btb_2bit #(.ENTRIES(16), .PC_W(32), .TAG_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'(pc[13:6]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    e_valid  = 1'b0;
    e_taken  = 1'b0;
    e_target = '0;
  endtask

  task automatic step(input logic lv, input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic fl);
    int li, ui;
    bit hit;
    @(negedge clk);
    lookup_valid  = lv;
    lookup_pc     = lpc;
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
    flush         = fl;
    li = idx_of(lpc);
    ui = idx_of(upc);
    e_valid = lv;
    if (lv) begin
      hit      = m_valid[li] && (m_tag[li] == tag_of(lpc));
      e_taken  = hit && (m_ctr[li] >= 2);
      e_target = e_taken ? m_tgt[li] : lpc + 32'd4;
    end
    if (fl) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      hit = m_valid[ui] && (m_tag[ui] == tag_of(upc));
      if (hit) begin
        m_ctr[ui] = ut ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1) : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
        if (ut) m_tgt[ui] = utgt;
      end else if (ut) begin
        m_valid[ui] = 1'b1;
        m_tag[ui]   = tag_of(upc);
        m_tgt[ui]   = utgt;
        m_ctr[ui]   = 2;
      end
    end
    @(posedge clk);
    #1;
    check("pred_valid", 32'(pred_valid), 32'(e_valid));
    check("pred_taken", 32'(pred_taken), 32'(e_taken));
    check("pred_target", pred_target, e_target);
  endtask

  task automatic lk(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic up(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    step(1'b0, '0, 1'b1, pc, t, tgt, 1'b0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    flush        = 1'b0;
    rst          = 1'b1;
    #1;
    model_reset();
    check("rst_valid", 32'(pred_valid), 32'd0);
    check("rst_taken", 32'(pred_taken), 32'd0);
    check("rst_target", pred_target, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pc, tgt;
    model_reset();
    #2;
    check("reset_valid", 32'(pred_valid), 32'd0);
    check("reset_taken", 32'(pred_taken), 32'd0);
    check("reset_target", pred_target, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lk(32'h1000);
    check("s1_target", pred_target, 32'h1004);
    up(32'h1000, 1'b1, 32'h2000);
    lk(32'h1000);
    check("s2_target", pred_target, 32'h2000);
    up(32'h1000, 1'b0, '0);
    up(32'h1000, 1'b0, '0);
    lk(32'h1000);
    check("s3_nt_target", pred_target, 32'h1004);
    for (int i = 0; i < 4; i++) up(32'h1000, 1'b1, 32'h2000);
    up(32'h1000, 1'b0, '0);
    lk(32'h1000);
    check("s3_sat_taken", 32'(pred_taken), 32'd1);
    up(32'h1000, 1'b0, '0);
    up(32'h1000, 1'b1, 32'h2000);
    lk(32'h1100);
    check("s4_alias_target", pred_target, 32'h1104);
    up(32'h1100, 1'b1, 32'h6000);
    lk(32'h1000);
    check("s4_evicted", pred_target, 32'h1004);
    up(32'h1000, 1'b1, 32'h2000);
    step(1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1, 32'h3000, 1'b0);
    check("s5_old_target", pred_target, 32'h2000);
    lk(32'h1000);
    check("s5_new_target", pred_target, 32'h3000);
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1, 32'h7000, 1'b1);
    check("s6_preflush", pred_target, 32'h3000);
    lk(32'h1000);
    check("s6_flushed", pred_target, 32'h1004);
    lk(32'hFFFF_FFFC);
    check("s6_wrap", pred_target, 32'h0000_0000);
    up(32'h1000, 1'b1, 32'h2000);
    lk(32'h1000);
    mid_reset();
    lk(32'h1000);
    for (int n = 0; n < 600; n++) begin
      pc  = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
      tgt = $urandom & 32'hFFFF_FFFC;
      step(1'($urandom_range(0, 3) != 0), pc,
           1'($urandom_range(0, 1)), ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2),
           1'($urandom_range(0, 2) != 0), tgt,
           1'($urandom_range(0, 49) == 0));
      if (n == 300) mid_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
